// File: rtl/softex_pkg.sv
// Shared softex definitions: FMA arbiter tag type, requester count and indices.
package softex_pkg;

    localparam int unsigned N_FMA_REQ    = 2;
    localparam int unsigned FMA_REQ_ACC  = 0;
    localparam int unsigned FMA_REQ_INV  = 1;

    // Widest requester id a tag can carry (up to 16 requesters).
    localparam int unsigned FMA_ARB_ID_W = 4;

    typedef struct packed {
        logic                    valid;
        logic [FMA_ARB_ID_W-1:0] id;
    } fma_arb_tag_t;

endpackage

// File: rtl/softex_rr_arbiter.sv
// Combinational round-robin picker: first set request scanning up from ptr, wrapping.
module softex_rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    int unsigned      j;
    logic [IDX_W-1:0] sel;

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        j       = 0;
        sel     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j   = (32'(ptr) + k) % N;
            sel = IDX_W'(j);
            if (!gnt_any && req[sel]) begin
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/softex_fma_arbiter.sv
// Shares one fixed-latency FMA among N_REQ requesters, round-robin, and routes
// each result back via a tag pipe. Optional arbitration lock: SOFTEX_FMA_ARB_LOCK_EN.
module softex_fma_arbiter
    import softex_pkg::*;
#(
    parameter int unsigned N_REQ    = N_FMA_REQ,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned FMA_REGS = 3,
    parameter int unsigned MAX_OUT  = FMA_REGS
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic [N_REQ-1:0]               req_valid_i,
    output logic [N_REQ-1:0]               req_ready_o,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_a_i,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_b_i,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_c_i,
`ifdef SOFTEX_FMA_ARB_LOCK_EN
    input  logic [N_REQ-1:0]               lock_i,
`endif
    output logic                           fma_valid_o,
    output logic [DATA_W-1:0]              fma_a_o,
    output logic [DATA_W-1:0]              fma_b_o,
    output logic [DATA_W-1:0]              fma_c_o,
    input  logic                           fma_valid_i,
    input  logic [DATA_W-1:0]              fma_res_i,
    output logic [N_REQ-1:0]               rsp_valid_o,
    output logic [DATA_W-1:0]              rsp_data_o,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned DRN_W = $clog2(FMA_REGS + 1);

    logic [IDX_W-1:0]              rr_q;
    fma_arb_tag_t [FMA_REGS-1:0]   tag_q;
    logic [N_REQ-1:0][CNT_W-1:0]   outst_q;
    logic [DRN_W-1:0]              drain_q;
    logic                          err_q;

    logic [N_REQ-1:0]              elig_base, elig, gnt, rsp_hit;
    logic [IDX_W-1:0]              gnt_idx;
    logic                          gnt_any, lock_act, busy_any;

`ifdef SOFTEX_FMA_ARB_LOCK_EN
    logic             lock_q;
    logic [IDX_W-1:0] lock_id_q;

    // Lock holds only while the locked requester keeps lock_i asserted.
    assign lock_act = lock_q & lock_i[lock_id_q];

    // Capture the lock on a grant with lock_i set; release when it drops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else if (clear_i) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else if (gnt_any) begin
            lock_q    <= lock_i[gnt_idx];
            lock_id_q <= gnt_idx;
        end else if (lock_q && !lock_i[lock_id_q]) begin
            lock_q    <= 1'b0;
        end
    end
`else
    assign lock_act = 1'b0;
`endif

    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        // A result for i can only come from the last tag stage.
        assign rsp_hit[i] = tag_q[FMA_REGS-1].valid & fma_valid_i & ~clear_i &
                            (tag_q[FMA_REGS-1].id == FMA_ARB_ID_W'(i));

        // At the credit limit a returning result frees the slot in the same cycle.
        assign elig_base[i] = req_valid_i[i] & ~clear_i &
                              ((outst_q[i] < CNT_W'(MAX_OUT)) |
                               ((outst_q[i] == CNT_W'(MAX_OUT)) & rsp_hit[i]));

`ifdef SOFTEX_FMA_ARB_LOCK_EN
        assign elig[i] = elig_base[i] & (~lock_act | (lock_id_q == IDX_W'(i)));
`else
        assign elig[i] = elig_base[i];
`endif

        // Outstanding count: +1 on grant, -1 on response, unchanged on both.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                outst_q[i] <= '0;
            end else if (clear_i) begin
                outst_q[i] <= '0;
            end else if (gnt[i] && !rsp_hit[i]) begin
                outst_q[i] <= outst_q[i] + 1'b1;
            end else if (!gnt[i] && rsp_hit[i] && outst_q[i] != '0) begin
                outst_q[i] <= outst_q[i] - 1'b1;
            end
        end
    end

    softex_rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) i_rr_arbiter (
        .ptr     (rr_q),
        .req     (elig),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign req_ready_o = gnt;
    assign fma_valid_o = gnt_any;
    assign fma_a_o     = gnt_any ? req_a_i[gnt_idx] : '0;
    assign fma_b_o     = gnt_any ? req_b_i[gnt_idx] : '0;
    assign fma_c_o     = gnt_any ? req_c_i[gnt_idx] : '0;
    assign rsp_valid_o = rsp_hit;
    assign rsp_data_o  = fma_res_i;
    assign err_o       = err_q;

    // Any valid tag means an operation is still inside the FMA.
    always_comb begin
        busy_any = 1'b0;
        for (int unsigned s = 0; s < FMA_REGS; s++) busy_any |= tag_q[s].valid;
    end
    assign busy_o = busy_any & ~clear_i;

    // Pointer, tag pipe, post-clear drain window and sticky tag/result error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q    <= IDX_W'(FMA_REQ_ACC);
            tag_q   <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
        end else if (clear_i) begin
            rr_q    <= IDX_W'(FMA_REQ_ACC);
            tag_q   <= '0;
            drain_q <= DRN_W'(FMA_REGS);
            err_q   <= 1'b0;
        end else begin
            if (gnt_any && !lock_act)
                rr_q <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            tag_q[0].valid <= gnt_any;
            tag_q[0].id    <= FMA_ARB_ID_W'(gnt_idx);
            for (int unsigned s = 1; s < FMA_REGS; s++) tag_q[s] <= tag_q[s-1];
            if (drain_q != '0) drain_q <= drain_q - 1'b1;
            if (drain_q == '0 && (tag_q[FMA_REGS-1].valid != fma_valid_i)) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_softex_fma_arbiter.sv
// Randomized bench for softex_fma_arbiter with a queue-based reference model
// and a separate response monitor.
module tb_softex_fma_arbiter;

    localparam int N   = 2;
    localparam int DW  = 16;
    localparam int LAT = 3;
    localparam int MO  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clear = 1'b0;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0][DW-1:0] ra = '0, rb = '0, rc = '0;
    logic [N-1:0]         ready;
    logic                 fma_valid;
    logic [DW-1:0]        fa, fb, fc;
    logic                 fma_vi;
    logic [DW-1:0]        fma_res;
    logic [N-1:0]         rsp_valid;
    logic [DW-1:0]        rsp_data;
    logic                 busy, err;
`ifdef SOFTEX_FMA_ARB_LOCK_EN
    logic [N-1:0]         lock = '0;
`endif

    always #5 clk = ~clk;

    softex_fma_arbiter #(
        .N_REQ(N), .DATA_W(DW), .FMA_REGS(LAT), .MAX_OUT(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .req_valid_i(req_valid), .req_ready_o(ready),
        .req_a_i(ra), .req_b_i(rb), .req_c_i(rc),
`ifdef SOFTEX_FMA_ARB_LOCK_EN
        .lock_i(lock),
`endif
        .fma_valid_o(fma_valid), .fma_a_o(fa), .fma_b_o(fb), .fma_c_o(fc),
        .fma_valid_i(fma_vi), .fma_res_i(fma_res),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
        .busy_o(busy), .err_o(err)
    );

    // Stand-in FMA: non-stallable, LAT cycles, plus an error injection override.
    logic [LAT-1:0]         pv = '0;
    logic [LAT-1:0][DW-1:0] pd = '0;
    logic                   inj = 1'b0;
    always @(posedge clk) begin
        pv <= {pv[LAT-2:0], fma_valid};
        pd <= {pd[LAT-2:0], fa * fb + fc};
    end
    assign fma_vi  = pv[LAT-1] | inj;
    assign fma_res = pd[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t exp_q[$];
    exp_t infl_q[$];
    int   outst[N];
    int   rr = 0;
    logic err_m = 1'b0;
    int   drain_end = -1;
    logic [N-1:0] acc = '0;
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference model: arbitration, credits and error from the rules, per cycle.
    logic [N-1:0]  m_ret, m_gnt;
    logic          m_resp;
    int            m_w;
    logic [DW-1:0] m_v;
    exp_t          m_e;
    initial begin
        for (int i = 0; i < N; i++) outst[i] = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("err", 32'(err), 32'(err_m));
                if (clear) begin
                    chk("clr_idle", {29'd0, busy, fma_valid, |ready}, 32'd0);
                    exp_q.delete();
                    infl_q.delete();
                    for (int i = 0; i < N; i++) outst[i] = 0;
                    rr = 0;
                    err_m = 1'b0;
                    drain_end = cyc + LAT;
                    acc = '0;
                end else begin
                    chk("busy", 32'(busy), 32'(infl_q.size() != 0));
                    m_ret = '0;
                    m_resp = 1'b0;
                    foreach (infl_q[k]) if (infl_q[k].due == cyc) begin
                        m_resp = 1'b1;
                        if (fma_vi) m_ret[infl_q[k].id] = 1'b1;
                    end
                    m_w = -1;
                    for (int k = 0; k < N; k++) begin
                        int i;
                        i = (rr + k) % N;
                        if (m_w < 0 && req_valid[i] &&
                            (outst[i] < MO || (outst[i] == MO && m_ret[i]))) m_w = i;
                    end
                    m_gnt = '0;
                    if (m_w >= 0) m_gnt[m_w] = 1'b1;
                    chk("grant", 32'(ready), 32'(m_gnt));
                    chk("fma_valid", 32'(fma_valid), 32'(m_w >= 0));
                    if (m_w >= 0) chk("operands", {fa, fb}, {ra[m_w], rb[m_w]});
                    else          chk("operands_idle", {fa, fb}, 32'd0);
                    if (cyc > drain_end && m_resp != fma_vi) err_m = 1'b1;
                    while (infl_q.size() != 0 && infl_q[0].due == cyc) void'(infl_q.pop_front());
                    for (int i = 0; i < N; i++) if (m_ret[i]) outst[i]--;
                    if (m_w >= 0) begin
                        outst[m_w]++;
                        rr = (m_w + 1) % N;
                        m_v = ra[m_w] * rb[m_w] + rc[m_w];
                        m_e.id = m_w; m_e.data = m_v; m_e.due = cyc + LAT;
                        infl_q.push_back(m_e);
                        exp_q.push_back(m_e);
                    end
                    acc = ready;
                end
            end
        end
    end

    // Monitor: every presented result must match the oldest expected one.
    exp_t mon_e;
    initial forever begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            while (exp_q.size() != 0 && exp_q[0].due < cyc) begin
                mon_e = exp_q.pop_front();
                chk("rsp_missing", 32'(0), 32'(mon_e.due));
            end
            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp", {rsp_valid, rsp_data, 8'(cyc)},
                        {2'(1 << mon_e.id), mon_e.data, 8'(mon_e.due)});
                end
            end
        end
    end

    // One cycle of stimulus; a request is only renewed or dropped once accepted.
    task automatic drive(input int p0, input int p1, input bit fixed);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || acc[i]) begin
                req_valid[i] = ($urandom_range(99) < ((i == 0) ? p0 : p1));
                ra[i] = fixed ? DW'(2) : DW'($urandom);
                rb[i] = fixed ? DW'(3) : DW'($urandom);
                rc[i] = fixed ? DW'(1) : DW'($urandom);
            end
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1; clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {27'd0, err, busy, fma_valid, ready}, 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // single requester, fixed operands (result 7)
        repeat (4) drive(100, 0, 1'b1);
        repeat (8) drive(0, 0, 1'b1);
        // fairness, both continuously valid
        repeat (8) drive(100, 100, 1'b0);
        repeat (8) drive(0, 0, 1'b0);
        // credit limit on requester 1
        repeat (6) drive(0, 100, 1'b0);
        repeat (8) drive(0, 0, 1'b0);

        // randomized traffic with occasional flushes
        for (int k = 0; k < 24; k++) begin
            int p0, p1;
            p0 = $urandom_range(100);
            p1 = $urandom_range(100);
            repeat (20) drive(p0, p1, 1'b0);
            if ($urandom_range(3) == 0) pulse_clear();
        end
        repeat (8) drive(0, 0, 1'b0);

        // clear with operations in flight; next grant goes to requester 0
        repeat (3) drive(100, 100, 1'b0);
        pulse_clear();
        @(negedge clk);
        chk("post_clear_gnt", 32'(ready), 32'd1);
        chk("post_clear_err", 32'(err), 32'd0);
        repeat (6) drive(100, 100, 1'b0);
        repeat (10) drive(0, 0, 1'b0);

        // spurious result with an empty tag pipe sets a sticky error
        @(posedge clk); #1; inj = 1'b1;
        @(posedge clk); #1; inj = 1'b0;
        @(negedge clk);
        chk("err_set", 32'(err), 32'd1);
        repeat (3) drive(0, 0, 1'b0);
        @(negedge clk);
        chk("err_held", 32'(err), 32'd1);
        pulse_clear();
        @(negedge clk);
        chk("err_cleared", 32'(err), 32'd0);

        repeat (8) drive(0, 0, 1'b0);
        @(negedge clk); #2;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/softex_fma_arbiter.md
Name: softex_fma_arbiter

Overview:
- Shares one fixed-latency, non-stallable FMA unit among N_REQ requesters, e.g. accumulation/reduction and Newton-Raphson inversion.
- Each cycle it issues at most one operation to the FMA, selected round-robin among eligible requesters.
- It tracks the requester ID of every in-flight operation and routes each FMA result back to its originating requester.
- Sits between the accumulator datapath and the shared FMA inside the softex accumulator.

Parameters:
- N_REQ, 2, number of requesters (>=2).
- DATA_W, 16, operand/result width.
- FMA_REGS, 3, FMA latency in cycles, issue to result (>=1).
- MAX_OUT, FMA_REGS, max outstanding operations per requester (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous flush.
- req_valid_i  in  N_REQ  operation request per requester.
- req_ready_o  out  N_REQ  grant; a request is accepted when valid&ready.
- req_a_i / req_b_i / req_c_i  in  N_REQ x DATA_W  operands, result = a*b+c.
- fma_valid_o  out  1  issue strobe to the FMA.
- fma_a_o / fma_b_o / fma_c_o  out  DATA_W  operands of the granted requester.
- fma_valid_i  in  1  FMA result valid.
- fma_res_i  in  DATA_W  FMA result.
- rsp_valid_o  out  N_REQ  one-hot result strobe.
- rsp_data_o  out  DATA_W  result, broadcast to all requesters.
- busy_o  out  1  any operation in flight.
- err_o  out  1  sticky; set when fma_valid_i disagrees with the tag pipe.

Behaviour:
- Reset and clear_i produce the same state:
  - rr_q=0; tag pipe all invalid; outstanding counters 0; err_o=0.
  - All outputs 0: rsp_valid_o, busy_o, req_ready_o, fma_valid_o.
  - While clear_i is high, no grant is issued.
  - In-flight results returning after a clear are discarded, without error, for FMA_REGS cycles (drain window counter).
- Eligibility: requester i is eligible when req_valid_i[i]=1 and outst[i]<MAX_OUT, or when outst[i]=MAX_OUT and a response to i is returning in the same cycle.
- Grant:
  - Combinational, same cycle. The winner is the first eligible i scanning from rr_q upward and wrapping modulo N_REQ.
  - req_ready_o is one-hot or zero.
  - fma_valid_o = |req_ready_o; fma operands are muxed from the winner. With no winner, operands are 0.
- Pointer: after a grant to i, rr_q <= (i+1) mod N_REQ. Without a grant, rr_q holds.
- Requesters must hold valid and operands stable until ready. The arbiter never drops an asserted request.
- Tag pipe:
  - FMA_REGS stages of {valid, id[$clog2(N_REQ)-1:0]}.
  - Stage 0 loads {fma_valid_o, winner}. Each stage shifts every cycle.
- Response:
  - rsp_valid_o[id] = last-stage valid & fma_valid_i; rsp_data_o = fma_res_i.
  - No backpressure: requesters must accept results in the cycle they are presented.
- Outstanding counters:
  - +1 on grant, -1 on response.
  - Grant and response to the same requester in the same cycle leave the count unchanged.
  - Width $clog2(MAX_OUT+1).
- busy_o = OR of tag pipe valids.
- Error: last-stage valid != fma_valid_i outside the drain window sets err_o, held until reset or clear.
- Latency: request accepted in cycle t produces its rsp_valid_o in cycle t+FMA_REGS.
- Throughput: one operation per cycle.

Optional Feature:
- Macro: SOFTEX_FMA_ARB_LOCK_EN.
- With the macro:
  - Adds input lock_i [N_REQ].
  - A grant to i while lock_i[i]=1 locks arbitration to i. Only i is eligible until a cycle in which lock_i[i]=0; other requesters wait.
  - rr_q does not advance while locked.
  - Used to keep a Newton-Raphson FMA/MUL chain back-to-back.
  - clear_i releases the lock.
- Without the macro: no lock_i port; pure round-robin.

Decomposition:
- Shared package softex_pkg gains:
  - fma_arb_tag_t, the struct {valid, id}.
  - Constant N_FMA_REQ = 2.
  - Named requester indices FMA_REQ_ACC=0 and FMA_REQ_INV=1.
- One sub-module: softex_rr_arbiter, a combinational round-robin priority picker with pointer input, request vector in, one-hot grant out.

Test Plan:
- Single requester: N_REQ=2, FMA_REGS=3, requester 0 valid 4 cycles with a=2,b=3,c=1 -> four grants; rsp_valid_o=01 cycles 3..6; result 7; busy_o drops after the last.
- Fairness: both valid continuously for 8 cycles -> grants alternate 0,1,0,1..., 4 each; responses alternate in the same order.
- Credit limit: MAX_OUT=2, requester 1 only -> grants at t0,t1, stall at t2, grant resumes at t3 when the first response returns. Counter never exceeds 2.
- Clear mid-flight: 3 operations in flight, clear_i pulsed -> no rsp_valid_o for the next 3 cycles, err_o=0, rr_q=0, counters 0; next grant goes to requester 0 if both are valid.
- Error: fma_valid_i forced 1 with an empty tag pipe -> err_o=1 the next cycle and held until clear_i.
- Lock (macro on): requester 1 locked for 4 grants while requester 0 is valid -> requester 0 gets no grant until lock_i[1]=0; then requester 0 is granted next.
